// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer timebase: RNG states,
// LFSR seed/taps and default widths.
package reaction_pkg;

  localparam int CNT_W_DEF    = 14;
  localparam int RND_BITS_DEF = 12;

  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: taps land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    RNG_IDLE  = 2'd0,
    RNG_GEN   = 2'd1,
    RNG_READY = 2'd2
  } rng_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Prescaler: counts 0..DIV-1 and emits a registered one-cycle tick while the
// count sits at DIV-1. Only reset and clear restart it.
module ms_tick_gen #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    if (clear) cnt_d = '0;
    tick_d = !clear && (cnt_d == LAST);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/reaction_timebase.sv
// Millisecond counter and random-delay generator for the reaction-timer game.
// Define REACTION_CNT_SAT_EN to make the counter saturate instead of wrapping.
module reaction_timebase
  import reaction_pkg::*;
#(
  parameter int         CLK_HZ        = 50_000_000,
  parameter int         TICK_HZ       = 1000,
  parameter int         CNT_W         = CNT_W_DEF,
  parameter int         RND_MIN       = 2000,
  parameter int         RND_BITS      = RND_BITS_DEF,
  parameter int         RND_SETTLE    = 16,
  parameter rng_state_e RNG_RST_STATE = RNG_GEN
) (
  input  logic             CLOCK50,
  input  logic             reset,
  input  logic             counter_reset,
  input  logic             counter_start,
  input  logic             counter_stop,
  input  logic             rng_resume,
  output logic [CNT_W-1:0] counter,
  output logic [CNT_W-1:0] random,
  output logic             rnd_ready,
  output logic             tick
);

  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int SETTLE_W = (RND_SETTLE > 1) ? $clog2(RND_SETTLE) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(RND_SETTLE - 1);

  logic tick_w;

  ms_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (CLOCK50),
    .reset (reset),
    .clear (!counter_reset),
    .tick  (tick_w)
  );

  logic                run_q, run_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [15:0]         lfsr_q, lfsr_d;
  rng_state_e          state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0]    random_q, random_d;
  logic                rnd_ready_q, rnd_ready_d;
  logic                rng_prev_q, rng_prev_d;
  logic                rng_req;
  logic [CNT_W-1:0]    rnd_draw;

  assign rng_req  = rng_prev_q && !rng_resume;
  assign rnd_draw = CNT_W'(RND_MIN) + CNT_W'(lfsr_q[RND_BITS-1:0]);

  // Increment gates on the next run value so a stop in a tick cycle wins.
  always_comb begin
    run_d = run_q;
    if (!counter_reset)     run_d = 1'b1;
    else if (!counter_stop) run_d = 1'b0;
    else if (counter_start) run_d = 1'b1;

    counter_d = counter_q;
    if (!counter_reset) begin
      counter_d = '0;
    end else if (tick_w && run_d) begin
`ifdef REACTION_CNT_SAT_EN
      if (counter_q != '1) counter_d = counter_q + CNT_W'(1);
`else
      counter_d = counter_q + CNT_W'(1);
`endif
    end

    lfsr_d = lfsr_next(lfsr_q);
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    random_d   = random_q;
    rng_prev_d = rng_resume;

    unique case (state_q)
      RNG_IDLE:  ;
      RNG_GEN: begin
        if (settle_q == SETTLE_LAST) begin
          random_d = rnd_draw;
          state_d  = RNG_READY;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      RNG_READY: ;
      default:   state_d = RNG_GEN;
    endcase

    // A new request always restarts the draw; a latch due this cycle is abandoned.
    if (rng_req) begin
      state_d  = RNG_GEN;
      settle_d = '0;
      random_d = random_q;
    end

    rnd_ready_d = (state_q == RNG_READY) && !rng_req;
  end

  always_ff @(posedge CLOCK50) begin
    if (reset) begin
      run_q       <= 1'b1;
      counter_q   <= '0;
      lfsr_q      <= LFSR_SEED;
      state_q     <= RNG_RST_STATE;
      settle_q    <= '0;
      random_q    <= '0;
      rnd_ready_q <= 1'b0;
      rng_prev_q  <= 1'b1;
    end else begin
      run_q       <= run_d;
      counter_q   <= counter_d;
      lfsr_q      <= lfsr_d;
      state_q     <= state_d;
      settle_q    <= settle_d;
      random_q    <= random_d;
      rnd_ready_q <= rnd_ready_d;
      rng_prev_q  <= rng_prev_d;
    end
  end

  assign counter   = counter_q;
  assign random    = random_q;
  assign rnd_ready = rnd_ready_q;
  assign tick      = tick_w;

endmodule

// File: tb/tb_reaction_timebase.sv
// Scoreboard bench for reaction_timebase: directed counter scenarios plus
// random draws checked by a monitor on each rising rnd_ready.
module tb_reaction_timebase;

  localparam int CLK_HZ     = 1000;
  localparam int TICK_HZ    = 100;
  localparam int CNT_W      = 8;
  localparam int RND_MIN    = 20;
  localparam int RND_BITS   = 4;
  localparam int RND_SETTLE = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             counter_reset = 1'b1;
  logic             counter_start = 1'b0;
  logic             counter_stop = 1'b1;
  logic             rng_resume = 1'b1;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] random;
  logic             rnd_ready;
  logic             tick;

  always #5 clk = ~clk;

  reaction_timebase #(
    .CLK_HZ     (CLK_HZ),
    .TICK_HZ    (TICK_HZ),
    .CNT_W      (CNT_W),
    .RND_MIN    (RND_MIN),
    .RND_BITS   (RND_BITS),
    .RND_SETTLE (RND_SETTLE)
  ) dut (
    .CLOCK50       (clk),
    .reset         (reset),
    .counter_reset (counter_reset),
    .counter_start (counter_start),
    .counter_stop  (counter_stop),
    .rng_resume    (rng_resume),
    .counter       (counter),
    .random        (random),
    .rnd_ready     (rnd_ready),
    .tick          (tick)
  );

  typedef struct {
    int value;
    int cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          pushes = 0;
  int          rises = 0;
  logic        ready_prev = 1'b0;
  logic [15:0] lfsr_m;

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // Value latched for a request sampled when the model register holds s.
  function automatic int model_draw(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < RND_SETTLE - 1; i++) t = model_step(t);
    return RND_MIN + int'(t[RND_BITS-1:0]);
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    lfsr_m <= reset ? 16'hACE1 : model_step(lfsr_m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on the negedge right after the request (or reset) edge.
  task automatic push_draw(input int value);
    exp_t e;
    e.value = value;
    e.cyc   = cyc + RND_SETTLE + 1;
    sb_q.push_back(e);
    pushes++;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int i;
    for (i = 0; i < budget && !rnd_ready; i++) step(1);
    if (!rnd_ready) check(name, 32'(rnd_ready), 32'd1);
  endtask

  task automatic wait_count(input string name, input int value, input bit need_tick, input int budget);
    int i;
    bit hit;
    hit = 1'b0;
    for (i = 0; i < budget; i++) begin
      if (int'(counter) == value && (!need_tick || tick)) begin
        hit = 1'b1;
        break;
      end
      step(1);
    end
    if (!hit) check(name, 32'(counter), 32'(value));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rnd_ready && !ready_prev) begin
      rises++;
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("draw_value", 32'(random), 32'(e.value));
        check("draw_latency", 32'(cyc), 32'(e.cyc));
        check("draw_range", 32'(random >= 8'd20 && random <= 8'd35), 32'd1);
      end
    end
    ready_prev = rnd_ready;
  end

  initial begin
    int first_tick;
    int ticks;
    logic [CNT_W-1:0] old_random;
    int i;

    // Reset state, then the automatic first draw: ACE1 -> 5670 -> AB38 -> 559C, nibble 12 -> 32.
    step(3);
    check("rst_counter", 32'(counter), 32'd0);
    check("rst_random", 32'(random), 32'd0);
    check("rst_ready", 32'(rnd_ready), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    push_draw(32);
    wait_ready("first_draw_timeout", 20);

    // Counter release: tick seen after the 9th edge, first increment on the 10th.
    counter_reset = 1'b0;
    step(3);
    check("clr_counter", 32'(counter), 32'd0);
    counter_reset = 1'b1;
    first_tick = -1;
    ticks = 0;
    for (int j = 1; j <= 100; j++) begin
      step(1);
      if (tick) begin
        ticks++;
        if (first_tick < 0) first_tick = j;
      end
      if (j == 9)  check("cnt_before_first_tick", 32'(counter), 32'd0);
      if (j == 10) check("cnt_first_tick", 32'(counter), 32'd1);
    end
    check("tick_count", 32'(ticks), 32'd10);
    check("first_tick_edge", 32'(first_tick), 32'd9);
    check("cnt_after_100", 32'(counter), 32'd10);

    // Stop coincident with tick at 5, start+stop together, then resume.
    counter_reset = 1'b0;
    step(1);
    counter_reset = 1'b1;
    wait_count("wait_cnt5_tick", 5, 1'b1, 200);
    counter_stop = 1'b0;
    step(1);
    check("stop_wins", 32'(counter), 32'd5);
    counter_stop = 1'b1;
    step(15);
    check("frozen", 32'(counter), 32'd5);
    counter_start = 1'b1;
    counter_stop  = 1'b0;
    step(12);
    check("start_stop_frozen", 32'(counter), 32'd5);
    counter_stop = 1'b1;
    step(1);
    counter_start = 1'b0;
    for (i = 0; i < 25 && counter == 8'd5; i++) step(1);
    check("resume_next", 32'(counter), 32'd6);

    // Past 255: wrap, or hold when saturating.
    counter_reset = 1'b0;
    step(1);
    counter_reset = 1'b1;
    step(2555);
    check("pre_wrap", 32'(counter), 32'd255);
    step(10);
`ifdef REACTION_CNT_SAT_EN
    check("wrap_or_sat", 32'(counter), 32'd255);
    step(20);
    check("sat_hold", 32'(counter), 32'd255);
`else
    check("wrap_or_sat", 32'(counter), 32'd0);
    step(20);
    check("wrap_continue", 32'(counter), 32'd2);
`endif
    counter_reset = 1'b0;
    step(1);
    check("clear_after_wrap", 32'(counter), 32'd0);
    counter_reset = 1'b1;

    // Two requests two cycles apart: one latch, timed from the second.
    wait_ready("ready_before_double", 20);
    old_random = random;
    rng_resume = 1'b0;
    step(1);
    check("req1_drop", 32'(rnd_ready), 32'd0);
    rng_resume = 1'b1;
    step(1);
    check("req1_low", 32'(rnd_ready), 32'd0);
    rng_resume = 1'b0;
    step(1);
    push_draw(model_draw(lfsr_m));
    check("req2_low", 32'(rnd_ready), 32'd0);
    rng_resume = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("gen_ready_low", 32'(rnd_ready), 32'd0);
      if (k <= 3) check("no_early_latch", 32'(random), 32'(old_random));
    end
    wait_ready("double_req_timeout", 10);

    // Reset in the middle of a draw with counter at 7.
    counter_reset = 1'b0;
    step(1);
    counter_reset = 1'b1;
    wait_count("wait_cnt7", 7, 1'b0, 200);
    rng_resume = 1'b0;
    step(1);
    rng_resume = 1'b1;
    check("gen_before_reset", 32'(rnd_ready), 32'd0);
    step(1);
    check("cnt7_before_reset", 32'(counter), 32'd7);
    reset = 1'b1;
    step(1);
    check("midrst_counter", 32'(counter), 32'd0);
    check("midrst_ready", 32'(rnd_ready), 32'd0);
    check("midrst_random", 32'(random), 32'd0);
    check("midrst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    push_draw(32);
    wait_ready("redraw_timeout", 20);

    for (i = 0; i < 20 && sb_q.size() != 0; i++) step(1);
    check("pending_draws", 32'(sb_q.size()), 32'd0);
    check("ready_rises", 32'(rises), 32'(pushes));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
